// File: rtl/my_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package my_serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Bit counter width; never below one bit so a W=2 build still has a counter.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/my_serial_adder_fa_cell.sv
// Combinational full-adder cell built from two half adders and an OR.
module my_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module my_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0_s;
  logic c0_s;
  logic c1_s;

  my_ha u_ha0 (.a(a),    .b(b),  .s(s0_s), .c(c0_s));
  my_ha u_ha1 (.a(s0_s), .b(ci), .s(s),    .c(c1_s));

  assign co = c0_s | c1_s;
endmodule

// File: rtl/my_serial_adder.sv
// Bit-serial W-bit adder: one shared full-adder cell processes one operand bit per clock, LSB first.
module my_serial_adder
  import my_serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int CW = cnt_width(W);

  state_t        state_r;
  logic [W-1:0]  sa_r;
  logic [W-1:0]  sb_r;
  logic [W-1:0]  sum_r;
  logic [CW-1:0] cnt_r;
  logic          carry_r;
  logic          cout_r;
  logic          busy_r;
  logic          done_r;
  logic          fa_sum_s;
  logic          fa_co_s;

  my_fa_cell u_fa (
    .a  (sa_r[0]),
    .b  (sb_r[0]),
    .ci (carry_r),
    .s  (fa_sum_s),
    .co (fa_co_s)
  );

  // Sequencer: operand capture, serial shift/accumulate, and the start/busy/done handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      sa_r    <= {W{1'b0}};
      sb_r    <= {W{1'b0}};
      sum_r   <= {W{1'b0}};
      cnt_r   <= {CW{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            sa_r    <= a;
            sb_r    <= b;
            sum_r   <= {W{1'b0}};
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= S_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          sa_r    <= {1'b0, sa_r[W-1:1]};
          sb_r    <= {1'b0, sb_r[W-1:1]};
          sum_r   <= {fa_sum_s, sum_r[W-1:1]};
          carry_r <= fa_co_s;
          cnt_r   <= cnt_r + CW'(1);
          // Terminal bit: latch the final carry and hand over to the done pulse.
          if (cnt_r == CW'(W - 1)) begin
            cout_r  <= fa_co_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= S_RUN;
          end
        end
        S_DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_my_serial_adder.sv
// Scoreboard bench for my_serial_adder (W=4): directed scenarios plus randomized operands.
module tb_my_serial_adder;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ops   = 0;
  int n_done  = 0;

  logic [W:0] exp_q[$];
  logic [W:0] last_exp = '0;

  my_serial_adder #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: whenever the DUT signals done, pop the oldest expected result and compare.
  always @(negedge clk) begin
    if (busy && done) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_done_overlap: busy=%0b done=%0b (t=%0t)", busy, done, $time);
    end
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_unexpected: got done with sum=%0d cout=%0b, expected none", sum, cout);
      end else begin
        last_exp = exp_q.pop_front();
        check("result_sum", 32'(sum), 32'(last_exp[W-1:0]));
        check("result_cout", 32'(cout), 32'(last_exp[W]));
      end
    end
  end

  // One addition; optionally hammers start with other operands during the first three RUN cycles.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit noise);
    logic [W:0] e;
    @(negedge clk);
    a = xa;
    b = xb;
    start = 1'b1;
    @(posedge clk);
    e = {1'b0, xa} + {1'b0, xb};
    exp_q.push_back(e);
    n_ops++;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("sum_cleared", 32'(sum), 32'd0);
        check("cout_cleared", 32'(cout), 32'd0);
      end
      check("busy_run", 32'(busy), 32'd1);
      check("done_run", 32'(done), 32'd0);
      if (noise && i <= 3) begin
        start = 1'b1;
        a = 4'd9;
        b = 4'd9;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  // Idle cycles: no activity, and the last result is held.
  task automatic idle_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("hold_sum", 32'(sum), 32'(last_exp[W-1:0]));
      check("hold_cout", 32'(cout), 32'(last_exp[W]));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    do_op(4'd3, 4'd5, 1'b0);
    idle_hold(2);
    do_op(4'd15, 4'd1, 1'b0);
    idle_hold(10);
    do_op(4'd15, 4'd15, 1'b0);
    idle_hold(1);
    do_op(4'd0, 4'd0, 1'b0);
    idle_hold(1);
    do_op(4'd2, 4'd3, 1'b1);
    idle_hold(6);

    // Reset in the second RUN cycle discards the operation.
    @(negedge clk);
    a = 4'd7;
    b = 4'd6;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    last_exp = '0;
    idle_hold(6);
    do_op(4'd7, 4'd6, 1'b0);

    // Back-to-back: next start raised in the cycle right after done.
    do_op(4'd1, 4'd1, 1'b0);
    idle_hold(1);

    for (int k = 0; k < 20; k++) begin
      do_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      idle_hold(int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    check("done_count", 32'(n_done), 32'(n_ops));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/my_serial_adder.md
Name: my_serial_adder

Overview:
- Bit-serial W-bit adder controller. It time-shares a single full-adder cell, built from two my_ha half adders plus an OR, across all operand bits: one bit per clock, LSB first.
- It sits above the half-adder datapath and sequences operand shifting, carry feedback and result assembly.
- Handshake is start/busy/done.

Parameters:
- W, 8, operand and result width in bits (W >= 2).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  W  operand A; captured on the accepted start cycle.
- b  input  W  operand B; captured on the accepted start cycle.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse when sum/cout become valid.
- sum  output  W  result bits; held until the next accepted start.
- cout  output  1  final carry-out; held like sum.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high (rst); polarity and synchronicity are fixed.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, carry flop and bit counter are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1: load sa<=a, sb<=b, carry<=0, cnt<=0, sum<=0, cout<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, one bit per cycle:
  - fa inputs are sa[0], sb[0], carry.
  - sa and sb shift right by 1 (MSB filled with 0).
  - sum shifts right by 1 with the fa sum bit inserted at sum[W-1].
  - carry <= fa carry-out; cnt <= cnt+1.
  - When cnt==W-1 this cycle: cout <= fa carry-out; go to DONE.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- Latency: start accepted at edge t. RUN occupies cycles t+1..t+W. done is high in cycle t+W+1. Next start is accepted no earlier than cycle t+W+2.
- busy=1 exactly while state==RUN. done and busy are never high together.
- start in RUN or DONE: ignored. It is not queued, and operands are not re-sampled.
- a/b changes after acceptance: no effect on the current result.
- Arithmetic: {cout,sum} = a + b modulo 2^(W+1), unsigned. Wrap-around shows only as cout=1.
- Counter: cnt width is clog2(W). It must not wrap before its terminal compare at W-1.
- Reset mid-operation: rst=1 in any state wins over start and the FSM. All outputs return to reset values on that edge. The partial result is discarded and no done is issued.
- Simultaneous rst and start: reset wins; the start is lost.
- Full-adder cell is purely combinational:
  - ha0 (sa[0], sb[0]) gives s0, c0.
  - ha1 (s0, carry) gives s1, c1.
  - fa sum = s1; fa carry = c0|c1.

Decomposition:
- Shared include/package holds the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- One natural sub-module: my_fa_cell (ports a, b, ci, s, co), instantiating two my_ha plus the OR.
- The controller instantiates one my_fa_cell. All FSM, shift and counter logic stays in my_serial_adder.

Test Plan (W=4):
- Basic add: rst high 2 cycles, then a=3, b=5, start pulse. Required: busy high 4 cycles; done pulse 5 cycles after the start edge; sum=8, cout=0.
- Carry out: a=15, b=1. Required: sum=0, cout=1, done after 5 cycles; sum/cout held through 10 idle cycles.
- Max operands and zero: a=15, b=15 gives sum=14, cout=1. Then a=0, b=0 gives sum=0, cout=0. Check that sum clears to 0 on the accepting edge.
- Ignored start: a=2, b=3, start. Then during RUN drive start=1 with a=9, b=9 for 3 cycles. Required: sum=5, cout=0; exactly one done; no second RUN.
- Reset mid-op: start a=7, b=6, assert rst at the 2nd RUN cycle. Required: busy=0, done=0, sum=0, cout=0 next cycle, FSM in IDLE. A subsequent a=7, b=6 run gives sum=13, cout=0.
- Back-to-back: assert start in the cycle after done. Required: it is accepted, and the second result (a=1, b=1 → sum=2) is correct.
